re_ack_ctrl: RTL

Parametrised, clocked successor to the single-channel REack controller. Terminates `NCH` independent four-phase REreq/REack handshakes. Arbitrates them round-robin onto one shared sample engine (smp_req/smp_ack four-phase). Asserts each channel's acknowledge only after that channel's sample has completed. Sits between the request-side channel interfaces and the shared sampling stage of the controller datapath.

---
 rtl/re_ack_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/re_ack_ctrl.sv
// re_ack_ctrl
//   Terminates NCH independent four-phase REreq/REack handshakes and serves
//   them one at a time, round-robin, through a single shared four-phase
//   sample engine (smp_req/smp_ack). A channel is acknowledged only after its
//   sample has completed.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-low reset
//   re_req    in   NCH    per-channel request (asynchronous, synchronised here)
//   re_ack    out  NCH    per-channel acknowledge (registered, at most one high)
//   go_ml     in   1      inhibit: no new grant while high (sampled in IDLE only)
//   smp_req   out  1      request to the shared sample stage (registered)
//   smp_ack   in   1      sample-stage acknowledge (asynchronous, synchronised here)
//   grant_id  out  ID_W   channel being served, valid while busy
//   busy      out  1      engine not in IDLE
//   err       out  1      one-cycle sample-timeout pulse (REACK_TIMEOUT_EN only)
//
// Configuration
//   REACK_TIMEOUT_EN  when defined, a TMO_W-bit counter aborts a SAMPLE that
//                     lasts TMO_MAX cycles without smp_ack; err pulses once,
//                     no acknowledge is given and the engine goes through RTZ.

module re_ack_ctrl #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned ID_W    = $clog2(NCH),
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  re_req,
    output logic [NCH-1:0]  re_ack,
    input  logic            go_ml,
    output logic            smp_req,
    input  logic            smp_ack,
    output logic [ID_W-1:0] grant_id,
    output logic            busy
`ifdef REACK_TIMEOUT_EN
    ,
    output logic            err
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SAMPLE = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;
    localparam logic [1:0] S_RTZ    = 2'd3;

    localparam logic [ID_W-1:0] LAST_CH = ID_W'(NCH - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [NCH-1:0] req_m_q, req_s_q;
    logic           sack_m_q, sack_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_m_q  <= '0;
            req_s_q  <= '0;
            sack_m_q <= 1'b0;
            sack_s_q <= 1'b0;
        end else begin
            req_m_q  <= re_req;
            req_s_q  <= req_m_q;
            sack_m_q <= smp_ack;
            sack_s_q <= sack_m_q;
        end
    end

    // ------------------------------------------------------------------
    // Engine state
    // ------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic            sreq_q, sreq_d;
    logic [NCH-1:0]  ack_q, ack_d;

`ifdef REACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TMO_MAX - 1));
`endif

    // ------------------------------------------------------------------
    // Round-robin search: first requesting channel at or after ptr, with
    // wrap. The candidate index is folded back below NCH explicitly so the
    // search also works for non-power-of-two channel counts.
    // ------------------------------------------------------------------
    logic            arb_hit;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] cand_id;
    int unsigned     cand;

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        cand_id = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            cand_id = ID_W'(cand);
            if (!arb_hit && req_s_q[cand_id]) begin
                arb_hit = 1'b1;
                arb_idx = cand_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        sreq_d  = sreq_q;
        ack_d   = ack_q;
`ifdef REACK_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!go_ml && arb_hit) begin
                    gid_d   = arb_idx;
                    ptr_d   = (arb_idx == LAST_CH) ? '0 : arb_idx + 1'b1;
                    sreq_d  = 1'b1;
                    state_d = S_SAMPLE;
`ifdef REACK_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_SAMPLE: begin
                if (sack_s_q) begin
                    sreq_d  = 1'b0;
                    ack_d   = NCH'(1) << gid_q;
                    state_d = S_ACK;
                end
`ifdef REACK_TIMEOUT_EN
                // Abort: ptr already moved past this channel at grant time,
                // so its still-pending request simply competes again.
                else if (tmo_hit) begin
                    sreq_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RTZ;
                end else begin
                    tmo_d   = tmo_q + 1'b1;
                end
`endif
            end
            S_ACK: begin
                if (!req_s_q[gid_q]) begin
                    ack_d   = '0;
                    state_d = S_RTZ;
                end
            end
            S_RTZ: begin
                if (!sack_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                sreq_d  = 1'b0;
                ack_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            sreq_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            sreq_q  <= sreq_d;
            ack_q   <= ack_d;
        end
    end

`ifdef REACK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign re_ack   = ack_q;
    assign smp_req  = sreq_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != S_IDLE);

endmodule
